// File: rtl/updown_counter_core_if.sv
// Counter control/observation bundle between the driver (master) and the
// counter core (slave).
interface updown_counter_core_if #(
  parameter int WIDTH  = 4,
  parameter int WCNT_W = 8
);
  logic              load;
  logic              updown;
  logic [WIDTH-1:0]  data;
  logic [WIDTH-1:0]  data_out;
  logic              carry;
  logic              borrow;
  logic              ovf_sticky;
  logic              unf_sticky;
  logic [WCNT_W-1:0] wrap_count;
  logic [1:0]        dir_state;
  logic              dir_change;

  modport master (
    output load, updown, data,
    input  data_out, carry, borrow, ovf_sticky, unf_sticky,
           wrap_count, dir_state, dir_change
  );

  modport slave (
    input  load, updown, data,
    output data_out, carry, borrow, ovf_sticky, unf_sticky,
           wrap_count, dir_state, dir_change
  );
endinterface

// File: rtl/updown_counter_core.sv
// Loadable up/down counter with wrap/saturate boundary handling, wrap event
// flags, a saturating wrap counter and a direction-tracking FSM.
module updown_counter_core #(
  parameter int WIDTH     = 4,
  parameter int WRAP_MODE = 1,
  parameter int WCNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  updown_counter_core_if.slave  bus
);

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  localparam logic [WIDTH-1:0]  CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]  CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WCNT_W-1:0] WC_MAX   = {WCNT_W{1'b1}};
  localparam logic [WCNT_W-1:0] WC_ONE   = {{(WCNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              borrow_q, borrow_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  dir_e              dir_q, dir_d;
  logic              dchg_q, dchg_d;

  // Next-state: load has priority over counting; pulses default low.
  always_comb begin
    cnt_d    = cnt_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    dchg_d   = 1'b0;
    dir_d    = dir_q;
    if (bus.load) begin
      cnt_d = bus.data;
      dir_d = DIR_IDLE;
    end else begin
      if (bus.updown) begin
        if (cnt_q == CNT_MAX) begin
          carry_d = 1'b1;
          cnt_d   = (WRAP_MODE != 0) ? CNT_ZERO : CNT_MAX;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        if (cnt_q == CNT_ZERO) begin
          borrow_d = 1'b1;
          cnt_d    = (WRAP_MODE != 0) ? CNT_MAX : CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      case (dir_q)
        DIR_IDLE: dir_d = bus.updown ? DIR_UP : DIR_DOWN;
        DIR_UP: begin
          if (bus.updown) begin
            dir_d = DIR_UP;
          end else begin
            dir_d  = DIR_DOWN;
            dchg_d = 1'b1;
          end
        end
        DIR_DOWN: begin
          if (bus.updown) begin
            dir_d  = DIR_UP;
            dchg_d = 1'b1;
          end else begin
            dir_d = DIR_DOWN;
          end
        end
        default: dir_d = DIR_IDLE;
      endcase
    end
    ovf_d = ovf_q | carry_d;
    unf_d = unf_q | borrow_d;
    if ((carry_d || borrow_d) && (wcnt_q != WC_MAX)) begin
      wcnt_d = wcnt_q + WC_ONE;
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= CNT_ZERO;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      wcnt_q   <= {WCNT_W{1'b0}};
      dir_q    <= DIR_IDLE;
      dchg_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      wcnt_q   <= wcnt_d;
      dir_q    <= dir_d;
      dchg_q   <= dchg_d;
    end
  end

  assign bus.data_out   = cnt_q;
  assign bus.carry      = carry_q;
  assign bus.borrow     = borrow_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.unf_sticky = unf_q;
  assign bus.wrap_count = wcnt_q;
  assign bus.dir_state  = dir_q;
  assign bus.dir_change = dchg_q;

endmodule

// File: tb/tb_updown_counter_core.sv
// Randomized and directed bench: a wrapping and a saturating counter share one
// stimulus stream and are checked against an integer reference model.
module tb_updown_counter_core;

  localparam int WIDTH  = 4;
  localparam int WCNT_W = 8;
  localparam int MAXV   = (1 << WIDTH) - 1;
  localparam int WCMAX  = (1 << WCNT_W) - 1;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  updown_counter_core_if #(.WIDTH(WIDTH), .WCNT_W(WCNT_W)) uif_w ();
  updown_counter_core_if #(.WIDTH(WIDTH), .WCNT_W(WCNT_W)) uif_s ();

  updown_counter_core #(.WIDTH(WIDTH), .WRAP_MODE(1), .WCNT_W(WCNT_W)) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (uif_w.slave)
  );

  updown_counter_core #(.WIDTH(WIDTH), .WRAP_MODE(0), .WCNT_W(WCNT_W)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (uif_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, index 0 = wrapping counter, index 1 = saturating counter.
  int m_cnt [2];
  int m_wc  [2];
  int m_dir [2];   // last count direction: 0 none, +1 up, -1 down
  bit m_c   [2];
  bit m_b   [2];
  bit m_o   [2];
  bit m_u   [2];
  bit m_dc  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit ld, input bit ud, input int d);
    int stp;
    int nxt;
    for (int k = 0; k < 2; k++) begin
      m_c[k]  = 1'b0;
      m_b[k]  = 1'b0;
      m_dc[k] = 1'b0;
      if (r) begin
        m_cnt[k] = 0;
        m_o[k]   = 1'b0;
        m_u[k]   = 1'b0;
        m_wc[k]  = 0;
        m_dir[k] = 0;
      end else if (ld) begin
        m_cnt[k] = d;
        m_dir[k] = 0;
      end else begin
        stp = ud ? 1 : -1;
        nxt = m_cnt[k] + stp;
        if (nxt > MAXV || nxt < 0) begin
          if (ud) m_c[k] = 1'b1;
          else    m_b[k] = 1'b1;
          nxt = (k == 0) ? (nxt + MAXV + 1) % (MAXV + 1) : m_cnt[k];
        end
        m_cnt[k] = nxt;
        if (m_dir[k] != 0 && m_dir[k] != stp) m_dc[k] = 1'b1;
        m_dir[k] = stp;
        if (m_c[k]) m_o[k] = 1'b1;
        if (m_b[k]) m_u[k] = 1'b1;
        if ((m_c[k] || m_b[k]) && m_wc[k] < WCMAX) m_wc[k] = m_wc[k] + 1;
      end
    end
  endtask

  function automatic int dir_code(input int dir);
    return (dir == 0) ? 0 : ((dir > 0) ? 1 : 2);
  endfunction

  task automatic check_all();
    chk("wrap.data_out",   32'(uif_w.data_out),   32'(m_cnt[0]));
    chk("wrap.carry",      32'(uif_w.carry),      32'(m_c[0]));
    chk("wrap.borrow",     32'(uif_w.borrow),     32'(m_b[0]));
    chk("wrap.ovf",        32'(uif_w.ovf_sticky), 32'(m_o[0]));
    chk("wrap.unf",        32'(uif_w.unf_sticky), 32'(m_u[0]));
    chk("wrap.wrap_count", 32'(uif_w.wrap_count), 32'(m_wc[0]));
    chk("wrap.dir_state",  32'(uif_w.dir_state),  32'(dir_code(m_dir[0])));
    chk("wrap.dir_change", 32'(uif_w.dir_change), 32'(m_dc[0]));
    chk("sat.data_out",    32'(uif_s.data_out),   32'(m_cnt[1]));
    chk("sat.carry",       32'(uif_s.carry),      32'(m_c[1]));
    chk("sat.borrow",      32'(uif_s.borrow),     32'(m_b[1]));
    chk("sat.ovf",         32'(uif_s.ovf_sticky), 32'(m_o[1]));
    chk("sat.unf",         32'(uif_s.unf_sticky), 32'(m_u[1]));
    chk("sat.wrap_count",  32'(uif_s.wrap_count), 32'(m_wc[1]));
    chk("sat.dir_state",   32'(uif_s.dir_state),  32'(dir_code(m_dir[1])));
    chk("sat.dir_change",  32'(uif_s.dir_change), 32'(m_dc[1]));
  endtask

  // Apply one cycle of inputs to both counters, then check after the edge.
  task automatic cyc(input bit r, input bit ld, input bit ud, input int d);
    rst          = r;
    uif_w.load   = ld;
    uif_w.updown = ud;
    uif_w.data   = WIDTH'(d);
    uif_s.load   = ld;
    uif_s.updown = ud;
    uif_s.data   = WIDTH'(d);
    @(posedge clk);
    model_step(r, ld, ud, d);
    #1;
    check_all();
  endtask

  initial begin
    int d;
    bit r;
    bit ld;
    total = 0;
    bad   = 0;

    // Reset, then 17 up-counts through the wrap.
    cyc(1'b1, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    chk("reset.data_out", 32'(uif_w.data_out), 32'd0);
    chk("reset.dir_state", 32'(uif_w.dir_state), 32'd0);
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 1'b1, 0);
    chk("up17.data_out", 32'(uif_w.data_out), 32'd1);
    chk("up17.wrap_count", 32'(uif_w.wrap_count), 32'd1);
    chk("up17.sat_data_out", 32'(uif_s.data_out), 32'd15);

    // Load 2 and count down through zero.
    cyc(1'b0, 1'b1, 1'b0, 2);
    chk("load.dir_idle", 32'(uif_w.dir_state), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 0);
    chk("down4.data_out", 32'(uif_w.data_out), 32'd14);
    chk("down4.unf", 32'(uif_w.unf_sticky), 32'd1);

    // Boundary attempts from F upward and from 0 downward.
    cyc(1'b1, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b0, 15);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 0);
    chk("sat_up.wrap_count", 32'(uif_s.wrap_count), 32'd3);
    cyc(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 0);
    chk("sat_dn.wrap_count", 32'(uif_s.wrap_count), 32'd5);
    chk("sat_dn.data_out", 32'(uif_s.data_out), 32'd0);

    // Direction FSM sequence.
    cyc(1'b1, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b0, 1'b0, 0);
    chk("dir.first_flip", 32'(uif_w.dir_change), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b1, 1'b0, 5);
    cyc(1'b0, 1'b0, 1'b0, 0);
    chk("dir.after_load", 32'(uif_w.dir_change), 32'd0);
    chk("dir.after_load_state", 32'(uif_w.dir_state), 32'd2);

    // Reset overriding a load in the same cycle.
    cyc(1'b0, 1'b1, 1'b0, 7);
    cyc(1'b1, 1'b1, 1'b0, 10);
    chk("rst_mid.data_out", 32'(uif_w.data_out), 32'd0);

    // Long up-count run to saturate the wrap counter.
    for (int i = 0; i < 300 * 16; i++) cyc(1'b0, 1'b0, 1'b1, 0);
    chk("wc_sat.wrap", 32'(uif_w.wrap_count), 32'd255);
    chk("wc_sat.sat", 32'(uif_s.wrap_count), 32'd255);

    // Randomized traffic biased toward the boundary values.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      ld = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 2))
        0:       d = 0;
        1:       d = MAXV;
        default: d = int'($urandom_range(0, MAXV));
      endcase
      cyc(r, ld, 1'($urandom_range(0, 1)), d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_counter_core.md
# updown_counter_core

Loadable up/down counter. It is the design-under-test end of the counter interface: it samples the `load`, `updown` and `data` controls that the bus-functional model drives, and produces `data_out`, which the monitor observes. It also reports wrap events through pulse flags, sticky overflow/underflow flags, a saturating wrap counter and a direction-tracking state machine, so the monitor and scoreboard can check boundary behaviour without recomputing it.

## Interface
Parameters:
- `WIDTH`, default 4: counter and data width.
- `WRAP_MODE`, default 1: 1 = wrap around at the boundaries; 0 = saturate at the boundaries.
- `WCNT_W`, default 8: width of `wrap_count`.

Ports:
- `clk`  input  1: single clock; every register updates on its rising edge.
- `rst`  input  1: reset. Synchronous and active-high.
- `load`  input  1: when high, `data` is loaded into the counter.
- `updown`  input  1: count direction. 1 = count up, 0 = count down. Ignored while `load` is high.
- `data`  input  WIDTH: value to load.
- `data_out`  output  WIDTH: registered counter value.
- `carry`  output  1: one-cycle pulse when an up-count is attempted at all-ones.
- `borrow`  output  1: one-cycle pulse when a down-count is attempted at zero.
- `ovf_sticky`  output  1: set by any `carry`; cleared only by `rst`.
- `unf_sticky`  output  1: set by any `borrow`; cleared only by `rst`.
- `wrap_count`  output  WCNT_W: number of `carry` plus `borrow` events; saturates at all-ones.
- `dir_state`  output  2: direction FSM state. 00 = IDLE, 01 = UP, 10 = DOWN.
- `dir_change`  output  1: one-cycle pulse when the direction flips between UP and DOWN.

## Operation
- Inputs are sampled at the rising edge of `clk`. The driver changes them 1 time unit after an edge, so they are stable at the next edge.
- Priority within a cycle: `rst` first, then `load`, then counting. There is no idle or hold command; every non-reset, non-load cycle counts.
- Reset (sampled `rst` = 1): `data_out` = 0, `carry` = 0, `borrow` = 0, both sticky flags = 0, `wrap_count` = 0, `dir_state` = IDLE, `dir_change` = 0.
- Reset in the middle of a sequence overrides `load` and counting in that same cycle. No flag pulse is produced from the cycle in which reset was applied.
- Load: `data_out` <= `data`. `carry`, `borrow` and `dir_change` are 0. `dir_state` <= IDLE. Sticky flags and `wrap_count` are kept.
- Up-count:
  - `data_out` < max: `data_out` + 1.
  - `data_out` = max: becomes 0 when `WRAP_MODE` = 1, stays at max when `WRAP_MODE` = 0. `carry` = 1 in both modes.
- Down-count:
  - `data_out` > 0: `data_out` − 1.
  - `data_out` = 0: becomes max when `WRAP_MODE` = 1, stays at 0 when `WRAP_MODE` = 0. `borrow` = 1 in both modes.
- Arithmetic is modulo 2^WIDTH with no extra carry bit kept in `data_out`. Here max = 2^WIDTH − 1.
- `wrap_count` increments by 1 on each `carry` or `borrow` (at most one per cycle) and holds at 2^WCNT_W − 1.
- Direction FSM, evaluated on count cycles:
  - IDLE → UP when `updown` = 1; IDLE → DOWN when `updown` = 0. No `dir_change` pulse.
  - UP → DOWN and DOWN → UP assert `dir_change` = 1 for one cycle.
  - UP stays UP and DOWN stays DOWN with `dir_change` = 0.
  - Any load, from any state → IDLE.
  - Encoding 11 is unreachable; if it is ever seen, recover to IDLE on the next edge.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on every output after edge N, and are visible to the monitor at N+1 with its 1-unit input skew.
- All outputs are registered; there are no combinational paths from input to output.
- `carry`, `borrow` and `dir_change` are high for exactly one cycle per event.
- Back-to-back events each produce their own pulse. Example: `WRAP_MODE` = 0 with up-count held at max gives `carry` high every cycle.
- A load of max followed by an up-count gives `carry` on the second cycle, not on the load cycle.

## Test plan
- Reset then up-counting, WIDTH = 4, WRAP_MODE = 1: `rst` for 2 cycles, then `updown` = 1 for 17 cycles → `data_out` runs 1, 2, …, 15, 0, 1; `carry` pulses once, in the cycle `data_out` becomes 0; `ovf_sticky` = 1; `wrap_count` = 1; `dir_state` = UP.
- Load and count down through zero: load 4'h2, then `updown` = 0 for 4 cycles → `data_out` = 2, 1, 0, F, E; `borrow` pulses at the 0 → F transition; `unf_sticky` = 1; load-cycle outputs show `dir_state` = IDLE.
- Saturating mode, WRAP_MODE = 0: load F, then up-count for 3 cycles → `data_out` stays F; `carry` high on all 3 cycles; `wrap_count` = 3. Then load 0 and down-count 2 cycles → stays 0; `borrow` high on both cycles; `wrap_count` = 5.
- Direction FSM: from reset, up ×2, down ×1, up ×1, load 5, down ×1 → `dir_change` pulses exactly at the 2nd and 3rd direction changes; `dir_state` sequence is UP, UP, DOWN, UP, IDLE, DOWN; no pulse after the load.
- Reset mid-operation: with `data_out` = 7 and `load` = 1, `data` = A, assert `rst` in the same cycle → `data_out` = 0; sticky flags cleared; `wrap_count` = 0; `dir_state` = IDLE; no flag pulse.
- `wrap_count` saturation, WCNT_W = 8, WRAP_MODE = 1: up-count continuously for 300 × 16 cycles → `wrap_count` reaches 255 and holds there; `carry` keeps pulsing every 16 cycles.
